conv_kernel_engine: RTL
=======================

# conv_kernel_engine

Parametrised successor to the single-channel kernel compute block. It multiplies a K×K pixel window by a signed K×K coefficient kernel (K ≤ MAX_KERNEL, chosen per transaction) using LANES multiply-accumulates per cycle, then applies rounding, normalisation and saturation. It sits between the window buffer and the output pixel stream of the ISP (blur, sharpen, Sobel/Laplacian stages), with valid/ready handshakes on both sides.

## Interface
- MAX_KERNEL, 5, largest supported window edge
- PIX_W, 8, unsigned pixel width
- COEF_W, 8, signed coefficient width (two's complement)
- LANES, 1, taps consumed per cycle, 1..MAX_KERNEL
- clk  in  1  clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- input_matrix  in  [MAX_KERNEL][MAX_KERNEL][PIX_W]  pixel window, [y][x]
- kernel  in  [MAX_KERNEL][MAX_KERNEL][COEF_W]  signed coefficients, [y][x]
- kernel_size  in  $clog2(MAX_KERNEL+1)  active edge K
- shift  in  SHIFT_W  right-shift normalisation amount
- mode  in  1  0 = clamp signed result, 1 = absolute value then clamp
- in_valid / in_ready  in / out  1  input handshake
- clear  in  1  synchronous abort
- out_valid / out_ready  out / in  1  output handshake
- out_pixel  out  PIX_W  normalised result
- out_sat  out  1  result was clamped
- busy  out  1  state ≠ IDLE

## Operation
- ACC_W = PIX_W + COEF_W + 2·$clog2(MAX_KERNEL) + 1, signed; cannot overflow. SHIFT_W = $clog2(ACC_W).
- Pixels are zero-extended; products are signed.
- States:
  - IDLE: in_ready = 1 (and !clear). On in_valid && in_ready, snapshot matrix, kernel, K, shift and mode; acc ← 0; x = y = 0; go to ACCUM.
  - ACCUM: acc += Σ over l < LANES of pix[y][x+l]·coef[y][x+l]; a lane is masked when x+l ≥ K. If x+LANES ≥ K, then x ← 0 and y++; otherwise x += LANES. After row K−1, go to NORM.
  - NORM: r = (acc + (shift ? 1 << (shift−1) : 0)) >>> shift, arithmetic. If mode = 1, r ← |r|. Clamp to [0, 2^PIX_W − 1]; out_sat = clamp applied. Register out_pixel and out_sat; go to HOLD.
  - HOLD: out_valid = 1. On out_ready, go to IDLE.
- K = 0 is treated as 1. K > MAX_KERNEL is clamped to MAX_KERNEL.
- Input fields are sampled only at acceptance; later input changes have no effect.
- clear in any state: next state IDLE, out_valid ← 0, acc ← 0, outputs hold their last values. clear overrides a same-cycle input handshake (in_ready forced 0). clear in HOLD together with out_ready counts as a completed transfer from the sink's view, but the block still goes to IDLE.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_pixel 0, out_sat 0, busy 0, acc 0.
- Accept edge = cycle 0. ACCUM occupies cycles 1..N, where N = K·ceil(K/LANES). NORM is cycle N+1. out_valid is high from cycle N+2.
- out_pixel and out_sat are stable while out_valid && !out_ready.
- in_ready is low from acceptance until the cycle after the output handshake, so there is one IDLE cycle between transactions.
- Reset mid-operation aborts immediately; no partial result is emitted.

## Structure
- Shared package conv_pkg holds:
  - state enum {IDLE, ACCUM, NORM, HOLD}
  - mode constants
  - ACC_W and SHIFT_W as functions of the parameters
- One sub-module, kernel_tap_walker: x/y row-major counter with LANES stride. It outputs curr_x, curr_y, a lane mask and last_row. Lane multiplication, accumulation and normalisation stay in the top level.

## Test plan
- Box blur: K=3, LANES=1, all pixels 10, all coefficients 1, shift 0 → out_pixel 90, out_sat 0, out_valid first seen 11 cycles after accept.
- Gaussian: coefficients 1 2 1 / 2 4 2 / 1 2 1, all pixels 255, shift 4 → 4080 >> 4 = 255, out_sat 0.
- Saturation and mode: Laplacian (center −8, others 1), center pixel 200, others 0, shift 3.
  - mode 0 → out_pixel 0, out_sat 1.
  - mode 1 → out_pixel 200, out_sat 0.
  - Separately, all coefficients 127, all pixels 255, shift 0 → 255, out_sat 1.
- Rounding: acc 9, shift 1 → 5. acc −3, shift 1 → −1 → clamped 0, out_sat 1.
- Lanes and size: LANES=2, K=5 → N=15, out_valid at accept+17. K=0 → computes pix[0][0]·coef[0][0] with N=1.
- Back-pressure and abort:
  - out_ready low for 5 cycles → out_pixel stable, in_ready 0, in_valid ignored.
  - clear at ACCUM cycle 3 → IDLE next cycle, out_valid stays 0, and the next transaction produces a correct result.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution kernel engine.
//   state_e      : engine FSM states
//   MODE_*       : result post-processing modes
//   acc_width()  : signed accumulator width that cannot overflow for a full window
//   shift_width(): width of the normalisation shift amount
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        NORM,
        HOLD
    } state_e;

    localparam logic MODE_CLAMP = 1'b0;  // clamp signed result to pixel range
    localparam logic MODE_ABS   = 1'b1;  // take magnitude, then clamp

    function automatic int acc_width(input int pix_w, input int coef_w, input int max_kernel);
        return pix_w + coef_w + 2 * $clog2(max_kernel) + 1;
    endfunction

    function automatic int shift_width(input int pix_w, input int coef_w, input int max_kernel);
        return $clog2(acc_width(pix_w, coef_w, max_kernel));
    endfunction

endpackage

// File: rtl/conv_kernel_engine_if.sv
// Bus bundle between the window buffer (source), the engine and the output
// pixel stream (sink).
//   input_matrix/kernel : [y][x] pixel window and signed coefficients
//   kernel_size/shift/mode : per-transaction controls, sampled on acceptance
//   in_valid/in_ready   : input handshake
//   out_valid/out_ready : output handshake, out_pixel/out_sat as payload
//   clear               : synchronous abort; busy : engine not idle
// slave = engine side, master = environment side.
interface conv_kernel_engine_if #(
    parameter int MAX_KERNEL = 5,
    parameter int PIX_W      = 8,
    parameter int COEF_W     = 8
);
    localparam int KW      = $clog2(MAX_KERNEL + 1);
    localparam int SHIFT_W = conv_pkg::shift_width(PIX_W, COEF_W, MAX_KERNEL);

    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIX_W-1:0]  input_matrix;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][COEF_W-1:0] kernel;
    logic [KW-1:0]      kernel_size;
    logic [SHIFT_W-1:0] shift;
    logic               mode;
    logic               in_valid;
    logic               in_ready;
    logic               clear;
    logic               out_valid;
    logic               out_ready;
    logic [PIX_W-1:0]   out_pixel;
    logic               out_sat;
    logic               busy;

    modport slave (
        input  input_matrix, kernel, kernel_size, shift, mode, in_valid, clear, out_ready,
        output in_ready, out_valid, out_pixel, out_sat, busy
    );

    modport master (
        output input_matrix, kernel, kernel_size, shift, mode, in_valid, clear, out_ready,
        input  in_ready, out_valid, out_pixel, out_sat, busy
    );

endinterface

// File: rtl/kernel_tap_walker.sv
// Row-major x/y walker over a KxK window, stepping LANES taps per advance.
//   clk, n_rst   : clock, asynchronous active-low reset
//   start_i      : restart at (0,0) (transaction accepted)
//   clear_i      : abort, back to (0,0)
//   advance_i    : consume one group of LANES taps
//   k_i          : effective window edge (1..MAX_KERNEL)
//   curr_x_o/curr_y_o : first tap of the current lane group
//   lane_mask_o  : lanes whose tap lies inside the row (x+l < K)
//   last_row_o   : current row is row K-1
//   row_end_o    : this group finishes the current row
module kernel_tap_walker #(
    parameter int MAX_KERNEL = 5,
    parameter int LANES      = 1,
    localparam int KW        = $clog2(MAX_KERNEL + 1),
    localparam int XW        = $clog2(MAX_KERNEL)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [KW-1:0]    k_i,
    output logic [XW-1:0]    curr_x_o,
    output logic [XW-1:0]    curr_y_o,
    output logic [LANES-1:0] lane_mask_o,
    output logic             last_row_o,
    output logic             row_end_o
);

    logic [XW-1:0] x_q;
    logic [XW-1:0] y_q;

    assign curr_x_o   = x_q;
    assign curr_y_o   = y_q;
    assign row_end_o  = (int'(x_q) + LANES) >= int'(k_i);
    assign last_row_o = (KW'(y_q) + KW'(1)) == k_i;

    // NOTE: combinational outputs get a default before any conditional write so no latch is inferred.
    always_comb begin
        lane_mask_o = '0;
        for (int l = 0; l < LANES; l++) begin
            lane_mask_o[l] = (int'(x_q) + l) < int'(k_i);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            x_q <= '0;
            y_q <= '0;
        end else if (start_i || clear_i) begin
            x_q <= '0;
            y_q <= '0;
        end else if (advance_i) begin
            if (row_end_o) begin
                x_q <= '0;
                y_q <= y_q + XW'(1);
            end else begin
                x_q <= x_q + XW'(LANES);
            end
        end
    end

endmodule

// File: rtl/conv_kernel_engine.sv
// KxK signed convolution of one pixel window with LANES MACs per cycle,
// followed by rounding right-shift, optional absolute value and clamping.
//   clk, n_rst : clock, asynchronous active-low reset
//   bus        : conv_kernel_engine_if.slave (input window/controls with
//                in_valid/in_ready, result with out_valid/out_ready, clear, busy)
module conv_kernel_engine
    import conv_pkg::*;
#(
    parameter int MAX_KERNEL = 5,
    parameter int PIX_W      = 8,
    parameter int COEF_W     = 8,
    parameter int LANES      = 1
) (
    input  logic                 clk,
    input  logic                 n_rst,
    conv_kernel_engine_if.slave  bus
);

    localparam int KW      = $clog2(MAX_KERNEL + 1);
    localparam int XW      = $clog2(MAX_KERNEL);
    localparam int ACC_W   = acc_width(PIX_W, COEF_W, MAX_KERNEL);
    localparam int SHIFT_W = shift_width(PIX_W, COEF_W, MAX_KERNEL);
    // Wide enough for acc plus the largest rounding bias 1 << (2^SHIFT_W - 1).
    localparam int NORM_W  = 2 ** SHIFT_W + 1;
    localparam logic signed [NORM_W-1:0] PIX_MAX = NORM_W'((1 << PIX_W) - 1);

    state_e state_q, state_d;

    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][PIX_W-1:0]  mat_q;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][COEF_W-1:0] coef_q;
    logic [KW-1:0]             k_q, k_eff;
    logic [SHIFT_W-1:0]        shift_q;
    logic                      mode_q;
    logic signed [ACC_W-1:0]   acc_q, lane_sum;
    logic [PIX_W-1:0]          out_pixel_q, pix_d;
    logic                      out_sat_q, sat_d;
    logic signed [NORM_W-1:0]  rnd, res, mag;
    logic                      accept;
    logic [XW-1:0]             curr_x, curr_y, tap_x;
    logic [LANES-1:0]          lane_mask;
    logic                      last_row, row_end;

    assign accept        = (state_q == IDLE) && bus.in_valid && !bus.clear;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_pixel = out_pixel_q;
    assign bus.out_sat   = out_sat_q;

    // K = 0 behaves as a 1x1 window; oversize K saturates to the largest window.
    always_comb begin
        k_eff = bus.kernel_size;
        if (bus.kernel_size == '0) begin
            k_eff = KW'(1);
        end else if (bus.kernel_size > KW'(MAX_KERNEL)) begin
            k_eff = KW'(MAX_KERNEL);
        end
    end

    kernel_tap_walker #(
        .MAX_KERNEL (MAX_KERNEL),
        .LANES      (LANES)
    ) u_walker (
        .clk         (clk),
        .n_rst       (n_rst),
        .start_i     (accept),
        .clear_i     (bus.clear),
        .advance_i   (state_q == ACCUM),
        .k_i         (k_q),
        .curr_x_o    (curr_x),
        .curr_y_o    (curr_y),
        .lane_mask_o (lane_mask),
        .last_row_o  (last_row),
        .row_end_o   (row_end)
    );

    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = !bus.clear;
                if (accept) state_d = ACCUM;
            end
            ACCUM:   if (last_row && row_end) state_d = NORM;
            NORM:    state_d = HOLD;
            HOLD:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.clear) state_d = IDLE;
    end

    // Pixels are zero-extended to signed before the multiply; masked lanes may
    // index past the window edge, their product is discarded.
    always_comb begin
        lane_sum = '0;
        tap_x    = '0;
        for (int l = 0; l < LANES; l++) begin
            tap_x = curr_x + XW'(l);
            if (lane_mask[l]) begin
                lane_sum = lane_sum + ACC_W'($signed({1'b0, mat_q[curr_y][tap_x]})
                                             * $signed(coef_q[curr_y][tap_x]));
            end
        end
    end

    // Round half up, arithmetic shift, optional magnitude, then clamp to pixel range.
    always_comb begin
        rnd = NORM_W'(acc_q);
        if (shift_q != '0) rnd = rnd + (NORM_W'(1) << (shift_q - SHIFT_W'(1)));
        res = rnd >>> shift_q;
        mag = res;
        unique case (mode_q)
            MODE_CLAMP: mag = res;
            MODE_ABS:   mag = res[NORM_W-1] ? -res : res;
        endcase
        pix_d = mag[PIX_W-1:0];
        sat_d = 1'b0;
        if (mag[NORM_W-1]) begin
            pix_d = '0;
            sat_d = 1'b1;
        end else if (mag > PIX_MAX) begin
            pix_d = '1;
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            k_q         <= KW'(1);
            shift_q     <= '0;
            mode_q      <= MODE_CLAMP;
            out_pixel_q <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (bus.clear || accept) begin
                acc_q <= '0;
            end else if (state_q == ACCUM) begin
                acc_q <= acc_q + lane_sum;
            end
            if (accept) begin
                k_q     <= k_eff;
                shift_q <= bus.shift;
                mode_q  <= bus.mode;
            end
            if (state_q == NORM && !bus.clear) begin
                out_pixel_q <= pix_d;
                out_sat_q   <= sat_d;
            end
        end
    end

    // NOTE: the window/kernel snapshot is data qualified by the FSM, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mat_q  <= bus.input_matrix;
            coef_q <= bus.kernel;
        end
    end

endmodule
